// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must hold the value k (iteration count loaded at accept).
    function automatic int unsigned cnt_width(input int unsigned k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned k = 48
) (
    input  logic [k-1:0] i_rem,
    input  logic         i_quo_msb,
    input  logic [k-1:0] i_divisor,
    output logic [k-1:0] o_rem,
    output logic         o_q_bit
);

    logic [k:0] w_t;
    logic [k:0] w_diff;
    logic       w_ge;

    assign w_t    = {i_rem, i_quo_msb};
    assign w_ge   = (w_t >= {1'b0, i_divisor});
    assign w_diff = w_t - {1'b0, i_divisor};

    // Incoming remainder is below the divisor, so both candidates fit in k bits.
    assign o_rem   = w_ge ? w_diff[k-1:0] : w_t[k-1:0];
    assign o_q_bit = w_ge;

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: 2k-bit dividend / k-bit divisor, valid/ready on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned k = 48
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*k-1:0] dividend,
    input  logic [k-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [k-1:0]   quotient,
    output logic [k-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = cnt_width(k);

    div_state_t    r_state;
    div_state_t    w_state_nxt;
    logic [k-1:0]  r_rem;
    logic [k-1:0]  r_quo;
    logic [k-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_accept;
    logic          w_exc;
    logic [k-1:0]  w_step_rem;
    logic          w_step_bit;

    assign w_accept = in_valid && (r_state == IDLE);
    // A zero divisor always satisfies hi >= divisor, so one compare covers both exceptions.
    assign w_exc    = (dividend[2*k-1:k] >= divisor);

    seq_divider_div_step #(.k(k)) u_step (
        .i_rem     (r_rem),
        .i_quo_msb (r_quo[k-1]),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = w_exc ? DONE : BUSY;
            BUSY:    if (r_cnt == CW'(1)) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_div <= divisor;
            if (w_exc) begin
                r_quo <= '1;
                r_rem <= dividend[k-1:0];
                r_cnt <= '0;
                r_dbz <= (divisor == '0);
                r_ovf <= (divisor != '0);
            end else begin
                r_quo <= dividend[k-1:0];
                r_rem <= dividend[2*k-1:k];
                r_cnt <= CW'(k);
                r_dbz <= 1'b0;
                r_ovf <= 1'b0;
            end
        end else if (r_state == BUSY) begin
            r_rem <= w_step_rem;
            r_quo <= {r_quo[k-2:0], w_step_bit};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand sequences, randomised model check.
module tb_seq_divider;

    localparam int unsigned K = 48;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*K-1:0] dividend;
    logic [K-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [K-1:0]   quotient;
    logic [K-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int nvec = 0;
    int nmis = 0;

    seq_divider #(.k(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*K-1:0] dvd;
        logic [K-1:0]   dsr;
        logic [K-1:0]   q;
        logic [K-1:0]   r;
        logic           dbz;
        logic           ovf;
        int             lat;
    } vec_t;

    task automatic chk(input string name, input logic [2*K-1:0] got, input logic [2*K-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // lat = rising edges after the accept edge until out_valid is seen (0 = visible right after accept).
    task automatic do_op(input logic [2*K-1:0] dvd, input logic [K-1:0] dsr, input bit consume,
                         output logic [K-1:0] q, output logic [K-1:0] r,
                         output logic dbz, output logic ovf, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {95'b0, in_ready}, 96'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 96'd0, 96'd1);
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        ovf = overflow;
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("in_ready_after_consume", {95'b0, in_ready}, 96'd1);
        end
    endtask

    // Reference: plain wide division; "doesn't fit" means quotient needs more than K bits.
    task automatic model(input logic [2*K-1:0] dvd, input logic [K-1:0] dsr,
                         output logic [K-1:0] q, output logic [K-1:0] r,
                         output logic dbz, output logic ovf, output int lat);
        logic [2*K-1:0] qf;
        logic [2*K-1:0] rf;
        if (dsr == '0) begin
            q = '1; r = dvd[K-1:0]; dbz = 1'b1; ovf = 1'b0; lat = 0;
        end else begin
            qf = dvd / {{K{1'b0}}, dsr};
            rf = dvd % {{K{1'b0}}, dsr};
            if (qf >= (96'd1 << K)) begin
                q = '1; r = dvd[K-1:0]; dbz = 1'b0; ovf = 1'b1; lat = 0;
            end else begin
                q = qf[K-1:0]; r = rf[K-1:0]; dbz = 1'b0; ovf = 1'b0; lat = K;
            end
        end
    endtask

    initial begin
        vec_t           vt[8];
        logic [K-1:0]   gq, gr, eq, er, hq, hr;
        logic           gdbz, govf, edbz, eovf;
        int             glat, elat;
        logic [2*K-1:0] rdvd;
        logic [K-1:0]   rdsr;

        vt[0] = '{96'hFFFFFFFFFFFE000000000001, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'h0, 1'b0, 1'b0, 48};
        vt[1] = '{96'd100, 48'd7, 48'd14, 48'd2, 1'b0, 1'b0, 48};
        vt[2] = '{96'h1234, 48'd0, 48'hFFFFFFFFFFFF, 48'h1234, 1'b1, 1'b0, 0};
        vt[3] = '{96'd1 << 48, 48'd1, 48'hFFFFFFFFFFFF, 48'h0, 1'b0, 1'b1, 0};
        vt[4] = '{(96'd5 << 48) | 96'hABC, 48'd5, 48'hFFFFFFFFFFFF, 48'hABC, 1'b0, 1'b1, 0};
        vt[5] = '{96'd0, 48'd3, 48'd0, 48'd0, 1'b0, 1'b0, 48};
        vt[6] = '{96'd4 << 48, 48'd5, 48'd225179981368524, 48'd4, 1'b0, 1'b0, 48};
        vt[7] = '{96'hFFFFFFFFFFFEFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFE, 1'b0, 1'b0, 48};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {95'b0, in_ready},    96'd1);
        chk("rst_out_valid", {95'b0, out_valid},   96'd0);
        chk("rst_quotient",  {48'b0, quotient},    96'd0);
        chk("rst_remainder", {48'b0, remainder},   96'd0);
        chk("rst_flags",     {94'b0, div_by_zero, overflow}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vt[i].dvd, vt[i].dsr, 1'b1, gq, gr, gdbz, govf, glat);
            chk($sformatf("vec%0d_quotient", i),  {48'b0, gq}, {48'b0, vt[i].q});
            chk($sformatf("vec%0d_remainder", i), {48'b0, gr}, {48'b0, vt[i].r});
            chk($sformatf("vec%0d_dbz", i),       {95'b0, gdbz}, {95'b0, vt[i].dbz});
            chk($sformatf("vec%0d_ovf", i),       {95'b0, govf}, {95'b0, vt[i].ovf});
            chk($sformatf("vec%0d_latency", i),   96'(glat), 96'(vt[i].lat));
        end

        // Output hold under back-pressure, with ignored in_valid pulses.
        do_op(96'd100, 48'd7, 1'b0, hq, hr, gdbz, govf, glat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c % 2 == 0);
            dividend = 96'd999 + 96'(c);
            divisor  = 48'd3;
            @(posedge clk);
            #1;
            chk("hold_out_valid", {95'b0, out_valid}, 96'd1);
            chk("hold_in_ready",  {95'b0, in_ready},  96'd0);
            chk("hold_quotient",  {48'b0, quotient},  96'd14);
            chk("hold_remainder", {48'b0, remainder}, 96'd2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_out_valid", {95'b0, out_valid}, 96'd0);
        chk("release_in_ready",  {95'b0, in_ready},  96'd1);
        chk("release_quotient",  {48'b0, quotient},  96'd14);
        chk("release_remainder", {48'b0, remainder}, 96'd2);

        // Asynchronous reset while the counter sits at 20 (28 iterations done).
        @(negedge clk);
        in_valid = 1'b1; dividend = 96'hDEAD_BEEF_0000_1234_5678; divisor = 48'hFFFF_0000_0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (28) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  {95'b0, in_ready},  96'd1);
        chk("midrst_out_valid", {95'b0, out_valid}, 96'd0);
        chk("midrst_quotient",  {48'b0, quotient},  96'd0);
        chk("midrst_remainder", {48'b0, remainder}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(96'd100, 48'd7, 1'b1, gq, gr, gdbz, govf, glat);
        chk("postrst_quotient",  {48'b0, gq}, 96'd14);
        chk("postrst_remainder", {48'b0, gr}, 96'd2);
        chk("postrst_latency",   96'(glat), 96'(K));

        for (int i = 0; i < 120; i++) begin
            rdvd = {$urandom(), $urandom(), $urandom()};
            if (i % 17 == 0)     rdsr = '0;
            else if (i % 4 == 0) rdsr = 48'($urandom_range(1, 255));
            else                 rdsr = {16'($urandom()), $urandom()};
            if (i % 3 != 0 && rdsr != '0) rdvd[2*K-1:K] = rdvd[2*K-1:K] % rdsr;
            model(rdvd, rdsr, eq, er, edbz, eovf, elat);
            do_op(rdvd, rdsr, 1'b1, gq, gr, gdbz, govf, glat);
            chk($sformatf("rnd%0d_quotient", i),  {48'b0, gq}, {48'b0, eq});
            chk($sformatf("rnd%0d_remainder", i), {48'b0, gr}, {48'b0, er});
            chk($sformatf("rnd%0d_flags", i),     {94'b0, gdbz, govf}, {94'b0, edbz, eovf});
            chk($sformatf("rnd%0d_latency", i),   96'(glat), 96'(elat));
            if (!edbz && !eovf)
                chk($sformatf("rnd%0d_identity", i), {48'b0, gq} * {48'b0, rdsr} + {48'b0, gr}, rdvd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
